dsp_mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate slice and successor to the DSP48A1 model. It adds configurable operand and result widths, signed arithmetic, and optional saturation with an overflow flag. It also adds a bank of NCH per-channel accumulators for time-interleaved filtering, and valid tagging through the pipe. It sits in the datapath between sample sources and the filter/accumulate back-end, and cascades slice-to-slice through PCIN/PCOUT.

---
 rtl/dsp_mac_pipe.sv | 124 ++++++++++++
 tb/tb_dsp_mac_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed multiply-accumulate slice: pre-adder, multiplier, post-adder
// with optional saturation, and a bank of per-channel accumulators.
module dsp_mac_pipe #(
    parameter int A_W    = 18,
    parameter int B_W    = 18,
    parameter int P_W    = 48,
    parameter int NCH    = 4,
    parameter bit SAT_EN = 1'b1,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    input  logic [CH_W-1:0] CH,
    input  logic [A_W-1:0]  A,
    input  logic [B_W-1:0]  B,
    input  logic [B_W-1:0]  D,
    input  logic [P_W-1:0]  C,
    input  logic [P_W-1:0]  PCIN,
    input  logic            CARRYIN,
    input  logic [4:0]      OPMODE,
    output logic            OUT_VALID,
    output logic [CH_W-1:0] OUT_CH,
    output logic [P_W-1:0]  P,
    output logic [P_W-1:0]  PCOUT,
    output logic            OVF
);
    localparam int RW = P_W + 2;
    localparam int MW = A_W + B_W + 1;
    localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NCH);
    localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

    logic signed [A_W-1:0] a1_q, a2_q;
    logic signed [B_W-1:0] b1_q, d1_q;
    logic signed [P_W-1:0] c1_q, c2_q, c3_q;
    logic                  ci1_q, ci2_q, ci3_q;
    logic [4:0]            op1_q;
    logic [2:0]            op2_q, op3_q;   // {POST_SUB, ZSEL}
    logic [CH_W-1:0]       ch1_q, ch2_q, ch3_q;
    logic                  v1_q, v2_q, v3_q;
    logic signed [B_W:0]   pre_d, pre2_q;
    logic signed [MW-1:0]  m_d, m3_q;

    logic signed [P_W-1:0] acc_q [NCH];
    logic signed [P_W-1:0] acc_rd, z;
    logic signed [RW-1:0]  addend, r_d;
    logic [2:0]            r_top;
    logic                  ovf_d, ch_ok;
    logic [P_W-1:0]        p_d;

    logic            out_valid_q, ovf_q;
    logic [CH_W-1:0] out_ch_q;
    logic [P_W-1:0]  p_q;

    always_comb begin
        pre_d = {b1_q[B_W-1], b1_q};
        if (op1_q[0]) begin
            pre_d = op1_q[1] ? (B_W+1)'(d1_q) - (B_W+1)'(b1_q)
                             : (B_W+1)'(d1_q) + (B_W+1)'(b1_q);
        end
    end

    assign m_d = MW'(a2_q) * MW'(pre2_q);

    always_comb begin
        ch_ok  = ({1'b0, ch3_q} < NCH_V);
        acc_rd = '0;
        if (ch_ok) acc_rd = acc_q[ch3_q];
        z = '0;
        case (op3_q[1:0])
            2'd1:    z = c3_q;
            2'd2:    z = acc_rd;
            2'd3:    z = PCIN;
            default: z = '0;
        endcase
        addend = RW'(m3_q) + RW'({1'b0, ci3_q});
        r_d    = op3_q[2] ? RW'(z) - addend : RW'(z) + addend;
        // R is in range only when the two guard bits match the P_W sign bit
        r_top  = r_d[RW-1:P_W-1];
        ovf_d  = (r_top != 3'b000) && (r_top != 3'b111);
        p_d    = r_d[P_W-1:0];
        if (ovf_d && SAT_EN) p_d = r_d[RW-1] ? P_MIN : P_MAX;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q <= '0; b1_q <= '0; d1_q <= '0; c1_q <= '0; ci1_q <= 1'b0;
            op1_q <= '0; ch1_q <= '0; v1_q <= 1'b0;
            a2_q <= '0; pre2_q <= '0; c2_q <= '0; ci2_q <= 1'b0;
            op2_q <= '0; ch2_q <= '0; v2_q <= 1'b0;
            m3_q <= '0; c3_q <= '0; ci3_q <= 1'b0;
            op3_q <= '0; ch3_q <= '0; v3_q <= 1'b0;
            out_valid_q <= 1'b0; out_ch_q <= '0; p_q <= '0; ovf_q <= 1'b0;
        end else begin
            a1_q <= A; b1_q <= B; d1_q <= D; c1_q <= C; ci1_q <= CARRYIN;
            op1_q <= OPMODE; ch1_q <= CH; v1_q <= IN_VALID;
            a2_q <= a1_q; pre2_q <= pre_d; c2_q <= c1_q; ci2_q <= ci1_q;
            op2_q <= op1_q[4:2]; ch2_q <= ch1_q; v2_q <= v1_q;
            m3_q <= m_d; c3_q <= c2_q; ci3_q <= ci2_q;
            op3_q <= op2_q; ch3_q <= ch2_q; v3_q <= v2_q;
            out_valid_q <= v3_q;
            if (v3_q) begin
                p_q      <= p_d;
                ovf_q    <= ovf_d;
                out_ch_q <= ch3_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else if (v3_q && ch_ok) begin
            acc_q[ch3_q] <= p_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_CH    = out_ch_q;
    assign P         = p_q;
    assign PCOUT     = p_q;
    assign OVF       = ovf_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a saturating and a wrapping instance share stimulus.
module tb_dsp_mac_pipe;
    logic        clk, rst, in_valid, cin;
    logic [1:0]  ch;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic [4:0]  opmode;

    logic        ov_s, ov_w, ovf_s, ovf_w;
    logic [1:0]  och_s, och_w;
    logic [47:0] p_s, p_w, pc_s, pc_w;

    int checks = 0;
    int passed = 0;

    dsp_mac_pipe #(.SAT_EN(1'b1)) dut_sat (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .CH(ch), .A(a), .B(b), .D(d),
        .C(c), .PCIN(pcin), .CARRYIN(cin), .OPMODE(opmode),
        .OUT_VALID(ov_s), .OUT_CH(och_s), .P(p_s), .PCOUT(pc_s), .OVF(ovf_s));

    dsp_mac_pipe #(.SAT_EN(1'b0)) dut_wrap (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .CH(ch), .A(a), .B(b), .D(d),
        .C(c), .PCIN(pcin), .CARRYIN(cin), .OPMODE(opmode),
        .OUT_VALID(ov_w), .OUT_CH(och_w), .P(p_w), .PCOUT(pc_w), .OVF(ovf_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [1:0] chn, input logic [17:0] av, input logic [17:0] bv,
                         input logic [17:0] dv, input logic [47:0] cv, input logic cinv,
                         input logic [4:0] op);
        in_valid = 1'b1; ch = chn; a = av; b = bv; d = dv; c = cv; cin = cinv; opmode = op;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; pcin = 48'(123);
        a = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
        c = {16'($urandom), 32'($urandom)}; cin = 1'b1; opmode = 5'b00101; ch = 2'd1;
        #1 rst = 1'b1;
        #1;
        checks++; if (p_s !== 48'd0) $display("FAIL rst_p: got %h expected 0", p_s); else passed++;
        checks++; if (pc_s !== 48'd0) $display("FAIL rst_pcout: got %h expected 0", pc_s); else passed++;
        checks++; if (ovf_s !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", ovf_s); else passed++;
        checks++; if (ov_s !== 1'b0) $display("FAIL rst_valid: got %b expected 0", ov_s); else passed++;
        checks++; if (och_s !== 2'd0) $display("FAIL rst_ch: got %0d expected 0", och_s); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (p_s !== 48'd0 || ov_s !== 1'b0)
            $display("FAIL rst_hold: got p=%h valid=%b expected 0/0", p_s, ov_s); else passed++;
        rst = 1'b0;
        idle();
        @(negedge clk);
    endtask

    task automatic run_one(input logic [1:0] chn, input logic [17:0] av, input logic [17:0] bv,
                           input logic [17:0] dv, input logic [47:0] cv, input logic cinv,
                           input logic [4:0] op);
        drive(chn, av, bv, dv, cv, cinv, op);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_preadd();
        run_one(2'd0, 18'd20, 18'd10, 18'd25, 48'd350, 1'b0, 5'b00101);
        checks++; if (ov_s !== 1'b1) $display("FAIL preadd_valid: got %b expected 1", ov_s); else passed++;
        checks++; if (p_s !== 48'd1050) $display("FAIL preadd_p: got %0d expected 1050", p_s); else passed++;
        checks++; if (pc_s !== 48'd1050) $display("FAIL preadd_pcout: got %0d expected 1050", pc_s); else passed++;
        checks++; if (ovf_s !== 1'b0) $display("FAIL preadd_ovf: got %b expected 0", ovf_s); else passed++;
        @(negedge clk);
        checks++; if (ov_s !== 1'b0) $display("FAIL preadd_pulse: got %b expected 0", ov_s); else passed++;
        run_one(2'd0, 18'd20, 18'd10, 18'd25, 48'd350, 1'b0, 5'b00011);
        checks++; if (p_s !== 48'd300) $display("FAIL presub_p: got %0d expected 300", p_s); else passed++;
        run_one(2'd0, -18'sd3, 18'd10, 18'd25, 48'd350, 1'b0, 5'b00011);
        checks++; if (p_s !== 48'hFFFF_FFFF_FFD3)
            $display("FAIL presub_neg: got %h expected ffffffffffd3", p_s); else passed++;
    endtask

    task automatic test_channels();
        logic [1:0]  tch [4];
        logic [4:0]  top [4];
        logic [17:0] ta [4];
        logic [17:0] tb [4];
        logic [47:0] texp [4];
        tch = '{2'd0, 2'd1, 2'd0, 2'd1};
        top = '{5'b00100, 5'b00100, 5'b01000, 5'b01000};
        ta  = '{18'd2, 18'd5, 18'd1, 18'd1};
        tb  = '{18'd3, 18'd5, 18'd4, 18'd1};
        texp = '{48'd6, 48'd25, 48'd10, 48'd26};
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) begin
                checks++; if (ov_s !== 1'b1 || p_s !== texp[i-4] || och_s !== tch[i-4])
                    $display("FAIL chan_%0d: got valid=%b p=%0d ch=%0d expected 1/%0d/%0d",
                             i-4, ov_s, p_s, och_s, texp[i-4], tch[i-4]);
                else passed++;
            end
            if (i < 4) drive(tch[i], ta[i], tb[i], 18'd0, 48'd0, 1'b0, top[i]);
            else idle();
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        run_one(2'd0, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 5'b00100);
        checks++; if (p_s !== 48'h7FFF_FFFF_FFFF) $display("FAIL sat_p: got %h expected 7fffffffffff", p_s); else passed++;
        checks++; if (ovf_s !== 1'b1) $display("FAIL sat_ovf: got %b expected 1", ovf_s); else passed++;
        checks++; if (p_w !== 48'h8000_0000_0000) $display("FAIL wrap_p: got %h expected 800000000000", p_w); else passed++;
        checks++; if (ovf_w !== 1'b1) $display("FAIL wrap_ovf: got %b expected 1", ovf_w); else passed++;
        run_one(2'd0, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 5'b00100);
        checks++; if (p_s !== 48'd1 || ovf_s !== 1'b0)
            $display("FAIL nosat: got p=%0d ovf=%b expected 1/0", p_s, ovf_s); else passed++;
        checks++; if (p_w !== 48'd1 || ovf_w !== 1'b0)
            $display("FAIL nowrap: got p=%0d ovf=%b expected 1/0", p_w, ovf_w); else passed++;
    endtask

    task automatic test_cascade_bubble();
        pcin = 48'd3000;
        drive(2'd0, 18'd5, 18'd6, 18'd0, 48'd0, 1'b1, 5'b11100);
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(2'd0, 18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 5'b01100);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (ov_s !== 1'b1 || p_s !== 48'd2969)
            $display("FAIL casc_sub: got valid=%b p=%0d expected 1/2969", ov_s, p_s); else passed++;
        @(negedge clk);
        checks++; if (ov_s !== 1'b0 || p_s !== 48'd2969)
            $display("FAIL casc_gap: got valid=%b p=%0d expected 0/2969", ov_s, p_s); else passed++;
        @(negedge clk);
        checks++; if (ov_s !== 1'b1 || p_s !== 48'd3006)
            $display("FAIL casc_add: got valid=%b p=%0d expected 1/3006", ov_s, p_s); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic seen;
        seen = 1'b0;
        drive(2'd2, 18'd1, 18'd1, 18'd0, 48'd5, 1'b0, 5'b00100);
        @(negedge clk);
        drive(2'd3, 18'd1, 18'd1, 18'd0, 48'd9, 1'b0, 5'b00100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        drive(2'd1, 18'd1, 18'd1, 18'd0, 48'd7, 1'b0, 5'b00100);
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            if (ov_s !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) $display("FAIL midrst_valid: got pulse=%b expected 0", seen); else passed++;
        checks++; if (p_s !== 48'd0) $display("FAIL midrst_p: got %0d expected 0", p_s); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) begin
                checks++; if (ov_s !== 1'b1 || p_s !== 48'd0 || och_s !== 2'(i-4))
                    $display("FAIL acc_clear_%0d: got valid=%b p=%0d ch=%0d expected 1/0/%0d",
                             i-4, ov_s, p_s, och_s, i-4);
                else passed++;
            end
            if (i < 4) drive(2'(i), 18'd0, 18'd7, 18'd0, 48'd0, 1'b0, 5'b01000);
            else idle();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_preadd();
        test_channels();
        test_saturation();
        test_cascade_bubble();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
